// File: rtl/timer_unit.sv
// timer_unit: memory-mapped prescaled 64-bit timer with compare match, sticky PEND and level irq; TIMER_AUTORELOAD_EN adds PERIOD and auto-reload of mtimecmp
module timer_unit #(
    parameter int          PRESC_W   = 16,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq
);
    logic               en;
    logic               ie;
    logic               arl;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pc;
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               pend;
    logic [7:0]         wr;
    logic               tick;
    logic               match_c;
    assign wr      = we ? 8'd1 << a : 8'd0;
    assign tick    = en && (pc == presc);
    assign match_c = mtime >= mtimecmp;
`ifdef TIMER_AUTORELOAD_EN
    logic [31:0] period;
    // control bits including auto-reload enable, plus the reload period
    always_ff @(posedge clk) begin
        if (rst) begin
            {arl, ie, en} <= 3'b000;
            period        <= '0;
        end else begin
            if (wr[0]) {arl, ie, en} <= d[2:0];
            if (wr[6]) period <= d;
        end
    end
    // compare register: a software write to either half beats the reload
    always_ff @(posedge clk) begin
        if (rst) mtimecmp <= CMP_RESET;
        else if (wr[4]) mtimecmp[31:0] <= d;
        else if (wr[5]) mtimecmp[63:32] <= d;
        else if (arl && match_c) mtimecmp <= mtimecmp + {32'd0, period};
    end
`else
    assign arl = 1'b0;
    // control bits; without auto-reload only EN and IE exist
    always_ff @(posedge clk) begin
        if (rst) {ie, en} <= 2'b00;
        else if (wr[0]) {ie, en} <= d[1:0];
    end
    // compare register halves, written by software only
    always_ff @(posedge clk) begin
        if (rst) mtimecmp <= CMP_RESET;
        else if (wr[4]) mtimecmp[31:0] <= d;
        else if (wr[5]) mtimecmp[63:32] <= d;
    end
`endif
    // prescaler divider register
    always_ff @(posedge clk) begin
        if (rst) presc <= '0;
        else if (wr[1]) presc <= d[PRESC_W-1:0];
    end
    // prescale counter: held at 0 while disabled or on a divider write, wraps on tick
    always_ff @(posedge clk) begin
        if (rst) pc <= '0;
        else pc <= (wr[1] || !en || tick) ? '0 : pc + PRESC_W'(1);
    end
    // free-running counter; a write to either half swallows a coincident tick
    always_ff @(posedge clk) begin
        if (rst) mtime <= '0;
        else if (wr[2]) mtime[31:0] <= d;
        else if (wr[3]) mtime[63:32] <= d;
        else if (tick) mtime <= mtime + 64'd1;
    end
    // sticky pending flag: a live match overrides a W1C, irq follows one clock later
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            irq  <= 1'b0;
        end else begin
            pend <= match_c || (pend && !(wr[7] && d[0]));
            irq  <= ie && pend;
        end
    end
    // same-cycle read mux, unused bits zero
    always_comb begin
        spo = '0;
        case (a)
            3'd0: spo = {29'd0, arl, ie, en};
            3'd1: spo = 32'(presc);
            3'd2: spo = mtime[31:0];
            3'd3: spo = mtime[63:32];
            3'd4: spo = mtimecmp[31:0];
            3'd5: spo = mtimecmp[63:32];
`ifdef TIMER_AUTORELOAD_EN
            3'd6: spo = period;
`endif
            3'd7: spo = {30'd0, irq, pend};
            default: spo = '0;
        endcase
    end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: table vectors, directed corner sequences and a random run against a reference model of timer_unit
module tb_timer_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  a = '0;
    logic [31:0] d = '0;
    logic [31:0] spo;
    logic        irq;
    int errors = 0;
    int checks = 0;

    timer_unit dut (.clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq));

    always #5 clk = ~clk;

    // reference model state, in the terms the register map uses
    logic        m_en, m_ie, m_arl, m_pend, m_irq;
    logic [15:0] m_n, m_pc;
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_per;

    task automatic model(input logic r, input logic w, input logic [2:0] ad, input logic [31:0] dd);
        logic tk, mt;
        if (r) begin
            {m_en, m_ie, m_arl, m_pend, m_irq} = '0;
            m_n = 0; m_pc = 0; m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_per = 0;
        end else begin
            tk = m_en && m_pc == m_n;
            mt = m_time >= m_cmp;
            m_irq = m_ie & m_pend;
            m_pend = mt | (m_pend & !(w && ad == 7 && dd[0]));
            m_pc = (!m_en || tk || (w && ad == 1)) ? 16'd0 : m_pc + 16'd1;
            if (w && ad == 2) m_time = {m_time[63:32], dd};
            else if (w && ad == 3) m_time = {dd, m_time[31:0]};
            else if (tk) m_time = m_time + 1;
            if (w && ad == 4) m_cmp = {m_cmp[63:32], dd};
            else if (w && ad == 5) m_cmp = {dd, m_cmp[31:0]};
`ifdef TIMER_AUTORELOAD_EN
            else if (m_arl && mt) m_cmp = m_cmp + {32'd0, m_per};
            if (w && ad == 6) m_per = dd;
            if (w && ad == 0) m_arl = dd[2];
`endif
            if (w && ad == 0) {m_ie, m_en} = dd[1:0];
            if (w && ad == 1) m_n = dd[15:0];
        end
    endtask

    function automatic logic [31:0] mread(input logic [2:0] ad);
        case (ad)
            3'd0: return {29'd0, m_arl, m_ie, m_en};
            3'd1: return {16'd0, m_n};
            3'd2: return m_time[31:0];
            3'd3: return m_time[63:32];
            3'd4: return m_cmp[31:0];
            3'd5: return m_cmp[63:32];
            3'd6: return m_per;
            default: return {30'd0, m_irq, m_pend};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clock edge with the given inputs; the model advances in lockstep
    task automatic step(input logic r, input logic w, input logic [2:0] ad, input logic [31:0] dd);
        rst = r; we = w; a = ad; d = dd;
        @(posedge clk);
        model(r, w, ad, dd);
        #1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [31:0] dd);
        step(1'b0, 1'b1, ad, dd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic rd(input logic [2:0] ad, output logic [31:0] v);
        we = 1'b0; a = ad; #1; v = spo;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  ad;
        logic [31:0] dd;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[17];

    initial begin
        logic [31:0] v;
        logic [31:0] e6, e_arl;
`ifdef TIMER_AUTORELOAD_EN
        e6 = 32'h0000_FFFF; e_arl = 32'd4;
`else
        e6 = 32'd0; e_arl = 32'd0;
`endif
        vt[0]  = '{1'b0, 3'd0, 32'd0, 32'd0};
        vt[1]  = '{1'b0, 3'd1, 32'd0, 32'd0};
        vt[2]  = '{1'b0, 3'd2, 32'd0, 32'd0};
        vt[3]  = '{1'b0, 3'd3, 32'd0, 32'd0};
        vt[4]  = '{1'b0, 3'd4, 32'd0, 32'hFFFF_FFFF};
        vt[5]  = '{1'b0, 3'd5, 32'd0, 32'hFFFF_FFFF};
        vt[6]  = '{1'b0, 3'd6, 32'd0, 32'd0};
        vt[7]  = '{1'b0, 3'd7, 32'd0, 32'd0};
        vt[8]  = '{1'b1, 3'd1, 32'h0001_2345, 32'h0000_2345};
        vt[9]  = '{1'b1, 3'd4, 32'h0000_0055, 32'h0000_0055};
        vt[10] = '{1'b1, 3'd5, 32'hAAAA_0000, 32'hAAAA_0000};
        vt[11] = '{1'b1, 3'd2, 32'h0000_1234, 32'h0000_1234};
        vt[12] = '{1'b1, 3'd3, 32'h0000_0077, 32'h0000_0077};
        vt[13] = '{1'b1, 3'd6, 32'h0000_FFFF, e6};
        vt[14] = '{1'b1, 3'd0, 32'hFFFF_FFF8, 32'd0};
        vt[15] = '{1'b1, 3'd0, 32'h0000_0004, e_arl};
        vt[16] = '{1'b1, 3'd7, 32'h0000_0001, 32'd0};

        step(1'b1, 1'b0, 3'd0, 32'd0);
        step(1'b1, 1'b0, 3'd0, 32'd0);
        chk("reset_irq", {63'd0, irq}, 64'd0);
        foreach (vt[i]) begin
            step(1'b0, vt[i].w, vt[i].ad, vt[i].dd);
            chk($sformatf("vec%0d_a%0d", i, vt[i].ad), {32'd0, spo}, {32'd0, vt[i].exp});
        end

        // prescale: N=3 gives one tick per 4 clocks
        step(1'b1, 1'b0, 3'd0, 32'd0);
        wr(3'd1, 32'd3);
        wr(3'd0, 32'd1);
        idle(40);
        rd(3'd2, v); chk("presc_lo", {32'd0, v}, 64'd10);
        rd(3'd3, v); chk("presc_hi", {32'd0, v}, 64'd0);
        wr(3'd0, 32'd0);
        idle(20);
        rd(3'd2, v); chk("presc_hold", {32'd0, v}, 64'd10);

        // LO to HI carry and write-over-tick priority
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd1);
        idle(1);
        rd(3'd2, v); chk("carry_lo", {32'd0, v}, 64'd0);
        rd(3'd3, v); chk("carry_hi", {32'd0, v}, 64'd1);
        wr(3'd2, 32'd5);
        rd(3'd2, v); chk("wr_over_tick_lo", {32'd0, v}, 64'd5);
        rd(3'd3, v); chk("wr_over_tick_hi", {32'd0, v}, 64'd1);

        // interrupt: PEND at mtime==20, irq one clock later, W1C blocked by live match
        step(1'b1, 1'b0, 3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd20);
        wr(3'd0, 32'd3);
        idle(20);
        rd(3'd7, v); chk("pend_before", {32'd0, v}, 64'd0);
        idle(1);
        rd(3'd7, v); chk("pend_set", {32'd0, v}, 64'd1);
        idle(1);
        rd(3'd7, v); chk("irq_follow", {32'd0, v}, 64'd3);
        chk("irq_pin", {63'd0, irq}, 64'd1);
        wr(3'd7, 32'd1);
        rd(3'd7, v); chk("w1c_blocked", {32'd0, v}, 64'd3);
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd7, 32'd1);
        rd(3'd7, v); chk("w1c_pend", {63'd0, v[0]}, 64'd0);
        idle(1);
        chk("w1c_irq", {63'd0, irq}, 64'd0);

        // W1C on the edge where the match first appears, then reset with irq high
        step(1'b1, 1'b0, 3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd5);
        wr(3'd0, 32'd3);
        idle(5);
        wr(3'd7, 32'd1);
        rd(3'd7, v); chk("set_beats_clear", {63'd0, v[0]}, 64'd1);
        idle(1);
        chk("irq_before_rst", {63'd0, irq}, 64'd1);
        step(1'b1, 1'b0, 3'd0, 32'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        rd(3'd2, v); chk("rst_mtime", {32'd0, v}, 64'd0);

`ifdef TIMER_AUTORELOAD_EN
        // auto-reload: each match advances mtimecmp by PERIOD
        wr(3'd1, 32'd0);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd10);
        wr(3'd6, 32'd10);
        wr(3'd0, 32'd7);
        idle(11);
        rd(3'd7, v); chk("arl_pend1", {63'd0, v[0]}, 64'd1);
        rd(3'd4, v); chk("arl_cmp20", {32'd0, v}, 64'd20);
        wr(3'd7, 32'd1);
        rd(3'd7, v); chk("arl_clear", {63'd0, v[0]}, 64'd0);
        idle(9);
        rd(3'd7, v); chk("arl_pend2", {63'd0, v[0]}, 64'd1);
        rd(3'd4, v); chk("arl_cmp30", {32'd0, v}, 64'd30);
        step(1'b1, 1'b0, 3'd0, 32'd0);
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, w;
            logic [2:0] ad;
            logic [31:0] dd;
            r  = $urandom_range(0, 199) == 0;
            w  = $urandom_range(0, 2) == 0;
            ad = 3'($urandom_range(0, 7));
            case (ad)
                3'd0: dd = $urandom_range(0, 7);
                3'd1: dd = $urandom_range(0, 2);
                3'd5: dd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'd0;
                3'd6: dd = $urandom_range(0, 15);
                3'd7: dd = $urandom;
                default: dd = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 80);
            endcase
            rst = r; we = w; a = ad; d = dd;
            #1;
            chk($sformatf("rnd%0d_spo_a%0d", i, ad), {32'd0, spo}, {32'd0, mread(ad)});
            chk($sformatf("rnd%0d_irq", i), {63'd0, irq}, {63'd0, m_irq});
            step(r, w, ad, dd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
